// File: rtl/blit_pkg.sv
// Shared types and default geometry for the sprite blitter.
package blit_pkg;

    localparam int FB_W_DEF    = 168;
    localparam int FB_H_DEF    = 104;
    localparam int SHEET_W_DEF = 96;
    localparam int SHEET_H_DEF = 120;
    localparam int ADDR_W_DEF  = 15;
    localparam int PAL_W_DEF   = 5;
    localparam int DIM_W_DEF   = 5;
    localparam int KEY_DEF     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_e;

endpackage

// File: rtl/blit_addr_gen.sv
// Pixel walker: latches the request, steps col/row and produces the sheet
// read address plus the unclipped destination coordinates of the current pixel.
module blit_addr_gen
    import blit_pkg::*;
#(
    parameter int SHEET_W = SHEET_W_DEF,
    parameter int SHEET_H = SHEET_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DIM_W   = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [7:0]        i_dst_x,
    input  logic [7:0]        i_dst_y,
    input  logic [6:0]        i_src_x,
    input  logic [6:0]        i_src_y,
    input  logic [DIM_W-1:0]  i_spr_w,
    input  logic [DIM_W-1:0]  i_spr_h,
    input  logic              i_flip_x,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [8:0]        o_dst_x,
    output logic [8:0]        o_dst_y,
    output logic              o_last
);

    // Headroom above the sheet size so the address sum is never clipped before truncation.
    localparam int AW = $clog2(SHEET_W * SHEET_H) + 3;

    logic [6:0]       r_src_x, r_src_y;
    logic [7:0]       r_dst_x, r_dst_y;
    logic [DIM_W-1:0] r_w, r_h, r_col, r_row;
    logic             r_flip;

    logic [DIM_W-1:0] w_sc;
    logic [AW-1:0]    w_sheet_y;
    logic [AW-1:0]    w_rom_full;
    logic             w_col_end;

    assign w_col_end  = (r_col == r_w - DIM_W'(1));
    assign o_last     = w_col_end && (r_row == r_h - DIM_W'(1));
    assign w_sc       = r_flip ? (r_w - DIM_W'(1) - r_col) : r_col;
    assign w_sheet_y  = AW'(r_src_y) + AW'(r_row);
    assign w_rom_full = w_sheet_y * AW'(SHEET_W) + AW'(r_src_x) + AW'(w_sc);
    assign o_rom_addr = w_rom_full[ADDR_W-1:0];
    assign o_dst_x    = 9'(r_dst_x) + 9'(r_col);
    assign o_dst_y    = 9'(r_dst_y) + 9'(r_row);

    // Request latch and raster-order col/row stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_x <= 7'd0;
            r_src_y <= 7'd0;
            r_dst_x <= 8'd0;
            r_dst_y <= 8'd0;
            r_w     <= '0;
            r_h     <= '0;
            r_flip  <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
        end else if (i_load) begin
            r_src_x <= i_src_x;
            r_src_y <= i_src_y;
            r_dst_x <= i_dst_x;
            r_dst_y <= i_dst_y;
            r_w     <= i_spr_w;
            r_h     <= i_spr_h;
            r_flip  <= i_flip_x;
            r_col   <= '0;
            r_row   <= '0;
        end else if (i_step) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= o_last ? '0 : r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: request FSM, one-cycle write stage behind the ROM,
// and clip / colour-key qualification of frame-buffer writes.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int SHEET_W = SHEET_W_DEF,
    parameter int SHEET_H = SHEET_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PAL_W   = PAL_W_DEF,
    parameter int DIM_W   = DIM_W_DEF,
    parameter int KEY     = KEY_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [7:0]        dst_x,
    input  logic [7:0]        dst_y,
    input  logic [6:0]        src_x,
    input  logic [6:0]        src_y,
    input  logic [DIM_W-1:0]  spr_w,
    input  logic [DIM_W-1:0]  spr_h,
    input  logic              flip_x,
    input  logic              key_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PAL_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PAL_W-1:0]  fb_data
);

    blit_state_e       r_state;
    logic              r_busy, r_done, r_key_en;
    logic              r_wr_vld, r_in_bounds;
    logic [ADDR_W-1:0] r_fb_addr;

    logic              w_load, w_step, w_zero, w_last, w_key_hit;
    logic [8:0]        w_dx, w_dy;
    logic [17:0]       w_fb_full;

    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_step    = (r_state == ST_RUN);
    assign w_zero    = (spr_w == DIM_W'(0)) || (spr_h == DIM_W'(0));
    assign w_fb_full = 18'(w_dy) * 18'(FB_W) + 18'(w_dx);

    blit_addr_gen #(
        .SHEET_W (SHEET_W),
        .SHEET_H (SHEET_H),
        .ADDR_W  (ADDR_W),
        .DIM_W   (DIM_W)
    ) u_addr_gen (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dst_x    (dst_x),
        .i_dst_y    (dst_y),
        .i_src_x    (src_x),
        .i_src_y    (src_y),
        .i_spr_w    (spr_w),
        .i_spr_h    (spr_h),
        .i_flip_x   (flip_x),
        .o_rom_addr (rom_addr),
        .o_dst_x    (w_dx),
        .o_dst_y    (w_dy),
        .o_last     (w_last)
    );

    // Request/completion FSM; a zero-size sprite still spends one busy cycle in DRAIN.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_key_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_key_en <= key_en;
                        r_state  <= w_zero ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write stage: destination address and clip result line up with rom_data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_vld    <= 1'b0;
            r_in_bounds <= 1'b0;
            r_fb_addr   <= '0;
        end else begin
            r_wr_vld    <= w_step;
            r_in_bounds <= (w_dx < 9'(FB_W)) && (w_dy < 9'(FB_H));
            r_fb_addr   <= w_fb_full[ADDR_W-1:0];
        end
    end

    // Colour key is judged on the live ROM word, so fb_we cannot be registered here.
    always_comb begin
        w_key_hit = 1'b0;
        if (r_key_en) begin
            w_key_hit = (rom_data == PAL_W'(KEY));
        end else begin
            w_key_hit = 1'b0;
        end
    end

    assign fb_we   = r_wr_vld && r_in_bounds && !w_key_hit;
    assign fb_addr = r_fb_addr;
    assign fb_data = rom_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference model pushes expected writes,
// a negedge monitor pops and compares every fb_we pulse.
module tb_sprite_blitter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  dst_x = 8'd0, dst_y = 8'd0;
    logic [6:0]  src_x = 7'd0, src_y = 7'd0;
    logic [4:0]  spr_w = 5'd0, spr_h = 5'd0;
    logic        flip_x = 1'b0, key_en = 1'b0;
    logic        busy, done, fb_we;
    logic [14:0] rom_addr, fb_addr;
    logic [4:0]  rom_data = 5'd0;
    logic [4:0]  fb_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit key_mode = 1'b0;
    int exp_addr_q[$];
    int exp_data_q[$];
    int we_cnt, first_addr, first_data, last_addr, first_rom;

    sprite_blitter dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start),
        .dst_x(dst_x), .dst_y(dst_y), .src_x(src_x), .src_y(src_y),
        .spr_w(spr_w), .spr_h(spr_h), .flip_x(flip_x), .key_en(key_en),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 CLK = ~CLK;

    function automatic int pix(input int x, input int y);
        if (key_mode && (x % 2 == 0)) return 0;
        return ((x + 3 * y) % 31) + 1;
    endfunction

    // Sheet ROM: one-cycle read latency.
    always @(posedge CLK) rom_data <= 5'(pix(int'(rom_addr) % 96, int'(rom_addr) / 96));

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every frame-buffer write must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (fb_we) begin
            we_cnt++;
            if (we_cnt == 1) begin
                first_addr = int'(fb_addr);
                first_data = int'(fb_data);
            end
            last_addr = int'(fb_addr);
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write_addr", int'(fb_addr), -1);
            end else begin
                chk("fb_addr", int'(fb_addr), exp_addr_q.pop_front());
                chk("fb_data", int'(fb_data), exp_data_q.pop_front());
            end
        end
    end

    task automatic push_model(input int dx, dy, sx, sy, w, h, input bit fl, ke, input int maxp);
        for (int p = 0; p < w * h && p < maxp; p++) begin
            int row, col, sc, d, x, y;
            row = p / w;
            col = p % w;
            sc  = fl ? (w - 1 - col) : col;
            d   = pix(sx + sc, sy + row);
            x   = dx + col;
            y   = dy + row;
            if (x < 168 && y < 104 && !(ke && d == 0)) begin
                exp_addr_q.push_back(y * 168 + x);
                exp_data_q.push_back(d);
            end
        end
    endtask

    // Drive a request; returns #1 after the accepting edge k (start of cycle k+1).
    task automatic issue(input int dx, dy, sx, sy, w, h, input bit fl, ke, hold, input int maxp);
        @(posedge CLK); #1;
        dst_x = 8'(dx); dst_y = 8'(dy); src_x = 7'(sx); src_y = 7'(sy);
        spr_w = 5'(w); spr_h = 5'(h); flip_x = fl; key_en = ke;
        start = 1'b1;
        we_cnt = 0;
        push_model(dx, dy, sx, sy, w, h, fl, ke, maxp);
        @(posedge CLK); #1;
        if (hold) spr_w = 5'd0;
        else start = 1'b0;
        dst_x = 8'hAA; src_x = 7'h15; flip_x = ~flip_x; key_en = ~key_en;
    endtask

    // Cycle-by-cycle busy/done check; n2>=0 models a second request accepted right after done.
    task automatic observe(input string nm, input int n1, n2, exp_we, input bit hold);
        int span, busy_bad, done_bad;
        busy_bad = 0;
        done_bad = 0;
        span = (n2 < 0) ? n1 + 4 : n1 + 3 + n2 + 4;
        for (int j = 1; j <= span; j++) begin
            bit eb, ed;
            if (j == 1) first_rom = int'(rom_addr);
            if (hold && j == n1 + 4) start = 1'b0;
            eb = (j <= n1 + 1) || (n2 >= 0 && j > n1 + 3 && j <= n1 + 3 + n2 + 1);
            ed = (j == n1 + 2) || (n2 >= 0 && j == n1 + 3 + n2 + 2);
            if (busy !== eb) busy_bad++;
            if (done !== ed) done_bad++;
            @(posedge CLK); #1;
        end
        chk({nm, "_busy_cycles"}, busy_bad, 0);
        chk({nm, "_done_cycles"}, done_bad, 0);
        chk({nm, "_write_count"}, we_cnt, exp_we);
        chk({nm, "_queue_left"}, exp_addr_q.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        issue(0, 0, 0, 0, 8, 8, 1'b0, 1'b0, 1'b0, 9999);
        observe("t1_8x8", 64, -1, 64, 1'b0);
        chk("t1_first_addr", first_addr, 0);
        chk("t1_last_addr", last_addr, 1183);

        issue(20, 10, 12, 0, 12, 12, 1'b1, 1'b0, 1'b0, 9999);
        observe("t2_flip", 144, -1, 144, 1'b0);
        chk("t2_first_rom", first_rom, 23);
        chk("t2_first_addr", first_addr, 1700);
        chk("t2_first_data", first_data, 24);
        chk("t2_last_addr", last_addr, 3559);

        issue(164, 100, 0, 0, 8, 8, 1'b0, 1'b0, 1'b0, 9999);
        observe("t3_clip", 64, -1, 16, 1'b0);
        chk("t3_last_addr", last_addr, 103 * 168 + 167);

        key_mode = 1'b1;
        issue(0, 0, 0, 0, 8, 8, 1'b0, 1'b1, 1'b0, 9999);
        observe("t4_key_on", 64, -1, 32, 1'b0);
        chk("t4_first_addr", first_addr, 1);
        issue(0, 0, 0, 0, 8, 8, 1'b0, 1'b0, 1'b0, 9999);
        observe("t4_key_off", 64, -1, 64, 1'b0);
        key_mode = 1'b0;

        // Reset lands inside cycle k+21 (pixel 20 issued), before pixel 19's write is sampled.
        issue(0, 0, 0, 0, 8, 8, 1'b0, 1'b0, 1'b0, 19);
        repeat (20) begin
            @(posedge CLK); #1;
        end
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t5_busy_in_rst", int'(busy), 0);
        chk("t5_fb_we_in_rst", int'(fb_we), 0);
        chk("t5_done_in_rst", int'(done), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("t5_writes_before_rst", we_cnt, 19);
        chk("t5_queue_left", exp_addr_q.size(), 0);
        issue(0, 0, 0, 0, 8, 8, 1'b0, 1'b0, 1'b0, 9999);
        observe("t5_after_rst", 64, -1, 64, 1'b0);

        issue(5, 5, 0, 0, 3, 2, 1'b0, 1'b0, 1'b1, 9999);
        observe("t6_hold_zero", 6, 0, 6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
